// File: rtl/fixed_point_iterative_complex_divider.sv
// Iterative signed fixed-point complex divider c = a/b: shared shift-add multiplier, restoring divider, val/rdy both sides.
// Optional dbz (divide-by-zero flag) output when FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN is defined.
`timescale 1ns/1ps
module fixed_point_iterative_complex_divider #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
  ,
  output logic         dbz
`endif
);
  localparam int CW = $clog2(n + d);
  localparam logic [CW-1:0] MUL_LAST = CW'(n - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(n + d - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;

  logic [n-1:0]   ar_r, ac_r, br_r, bc_r, den, nr, ni, quot_r;
  logic [2:0]     stage;
  logic [CW-1:0]  cnt;
  logic [2*n-1:0] acc;
  logic [n+d-1:0] q;
  logic [n-1:0]   rem;

  // Multiplier: operands chosen by stage, one partial product per cycle, acc restarts at cnt 0.
  logic [n-1:0]   op_a, op_b, mag_a, mag_b, prod;
  logic [2*n-1:0] addend, acc_next, prod_s;
  logic           b_bit, p_neg;

  always_comb begin
    op_a = ar_r;
    op_b = bc_r;
    case (stage)
      3'd0:    begin op_a = br_r; op_b = br_r; end
      3'd1:    begin op_a = bc_r; op_b = bc_r; end
      3'd2:    begin op_a = ar_r; op_b = br_r; end
      3'd3:    begin op_a = ac_r; op_b = bc_r; end
      3'd4:    begin op_a = ac_r; op_b = br_r; end
      default: begin op_a = ar_r; op_b = bc_r; end
    endcase
  end

  assign mag_a    = op_a[n-1] ? -op_a : op_a;
  assign mag_b    = op_b[n-1] ? -op_b : op_b;
  assign p_neg    = op_a[n-1] ^ op_b[n-1];
  assign b_bit    = |((mag_b >> cnt) & n'(1));
  assign addend   = b_bit ? ({{n{1'b0}}, mag_a} << cnt) : '0;
  assign acc_next = ((cnt == '0) ? '0 : acc) + addend;
  assign prod_s   = p_neg ? -acc_next : acc_next;
  assign prod     = n'(prod_s >> d);

  // Restoring divider on |num| << d; the dividend is injected at cnt 0.
  logic [n-1:0]   num, num_mag, rem_cur, rem_next, quot;
  logic [n+d-1:0] q_cur, q_next;
  logic [n:0]     rem_sh;
  logic           ge;

  assign num      = stage[0] ? ni : nr;
  assign num_mag  = num[n-1] ? -num : num;
  assign q_cur    = (cnt == '0) ? {num_mag, {d{1'b0}}} : q;
  assign rem_cur  = (cnt == '0) ? '0 : rem;
  assign rem_sh   = {rem_cur, q_cur[n+d-1]};
  assign ge       = rem_sh >= {1'b0, den};
  assign rem_next = n'(ge ? rem_sh - {1'b0, den} : rem_sh);
  assign q_next   = {q_cur[n+d-2:0], ge};
  assign quot     = (den == '0) ? '0 : (num[n-1] ? -q_next[n-1:0] : q_next[n-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      cr       <= '0;
      cc       <= '0;
      ar_r     <= '0;
      ac_r     <= '0;
      br_r     <= '0;
      bc_r     <= '0;
      den      <= '0;
      nr       <= '0;
      ni       <= '0;
      quot_r   <= '0;
      stage    <= '0;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      rem      <= '0;
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
      dbz      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (recv_val) begin
          ar_r     <= ar;
          ac_r     <= ac;
          br_r     <= br;
          bc_r     <= bc;
          stage    <= '0;
          cnt      <= '0;
          recv_rdy <= 1'b0;
          state    <= MUL;
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == MUL_LAST) begin
            cnt <= '0;
            case (stage)
              3'd0:    den <= prod;
              3'd1:    den <= den + prod;
              3'd2:    nr  <= prod;
              3'd3:    nr  <= nr + prod;
              3'd4:    ni  <= prod;
              default: ni  <= ni - prod;
            endcase
            if (stage == 3'd5) begin
              stage <= '0;
              state <= DIV;
            end else begin
              stage <= stage + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (den != '0) begin
            q   <= q_next;
            rem <= rem_next;
          end
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (stage == 3'd0) begin
              quot_r <= quot;
              stage  <= 3'd1;
            end else begin
              cr       <= quot_r;
              cc       <= quot;
              send_val <= 1'b1;
              stage    <= '0;
              state    <= DONE;
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
              dbz      <= (den == '0);
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (send_rdy) begin
          send_val <= 1'b0;
          recv_rdy <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_iterative_complex_divider.sv
// Self-checking bench: directed Q16.16 cases, random operands vs. an integer-arithmetic model, backpressure and mid-op reset.
`timescale 1ns/1ps
module tb_fixed_point_iterative_complex_divider;
  localparam int LAT = 6*32 + 2*(32+16);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [31:0] ar = '0, ac = '0, br = '0, bc = '0;
  logic        send_val;
  logic        send_rdy = 1'b1;
  logic [31:0] cr, cc;
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
  logic        dbz;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_point_iterative_complex_divider #(.n(32), .d(16)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .ar(ar), .ac(ac), .br(br), .bc(bc),
    .send_val(send_val), .send_rdy(send_rdy),
    .cr(cr), .cc(cc)
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
    , .dbz(dbz)
`endif
  );

  // Q16.16 product: exact signed 64-bit product, keep bits [47:16]
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pu;
    p  = longint'($signed(a)) * longint'($signed(b));
    pu = p;
    return pu[47:16];
  endfunction

  // Q16.16 quotient truncated toward zero; zero divisor gives zero
  function automatic logic [31:0] fdiv(input logic [31:0] num, input logic [31:0] den);
    longint s;
    longint unsigned mag, qq;
    logic [63:0] qv;
    logic [31:0] r;
    if (den == 32'd0) return 32'd0;
    s   = longint'($signed(num));
    mag = (s < 0) ? longint'(-s) : longint'(s);
    qq  = (mag << 16) / {32'd0, den};
    qv  = qq;
    r   = qv[31:0];
    if (s < 0) r = -r;
    return r;
  endfunction

  task automatic model(input logic [31:0] a_r, a_c, b_r, b_c, output logic [31:0] e_r, e_c);
    logic [31:0] den, nr, ni;
    den = fmul(b_r, b_r) + fmul(b_c, b_c);
    nr  = fmul(a_r, b_r) + fmul(a_c, b_c);
    ni  = fmul(a_c, b_r) - fmul(a_r, b_c);
    e_r = fdiv(nr, den);
    e_c = fdiv(ni, den);
  endtask

  function automatic logic [31:0] rnd();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) return v;
    return {{12{v[19]}}, v[19:0]};
  endfunction

  // Drive one operation; lat counts edges from accept to send_val (bounded)
  task automatic run_op(input logic [31:0] a_r, a_c, b_r, b_c, input bit hold,
                        output int lat, output logic [31:0] r_r, r_c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!recv_rdy && guard < 1000) begin @(negedge clk); guard++; end
    ar = a_r; ac = a_c; br = b_r; bc = b_c;
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom;
    lat = 0;
    while (!send_val && lat < 1000) begin @(posedge clk); #1; lat++; end
    r_r = cr;
    r_c = cc;
    if (!hold && send_val) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (recv_rdy !== 1'b1) begin fails++; $display("FAIL reset_recv_rdy got %b want 1", recv_rdy); end
    tests++; if (send_val !== 1'b0) begin fails++; $display("FAIL reset_send_val got %b want 0", send_val); end
    tests++; if (cr !== 32'd0 || cc !== 32'd0) begin fails++; $display("FAIL reset_outputs got %h/%h want 0/0", cr, cc); end
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
    tests++; if (dbz !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", dbz); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] v [5][4];
    logic [31:0] xr [5];
    logic [31:0] xc [5];
    logic [31:0] r_r, r_c;
    int lat;
    v[0] = '{32'h00010000, 32'h0, 32'h00010000, 32'h0};           xr[0] = 32'h00010000; xc[0] = 32'h0;
    v[1] = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000}; xr[1] = 32'h000070A3; xc[1] = 32'h0000147A;
    v[2] = '{32'hFFFC0000, 32'h0, 32'h0, 32'h00020000};           xr[2] = 32'h0;        xc[2] = 32'h00020000;
    v[3] = '{32'hFFFF0000, 32'h0, 32'h00030000, 32'h0};           xr[3] = 32'hFFFFAAAB; xc[3] = 32'h0;
    v[4] = '{32'h00050000, 32'h0, 32'h0, 32'h0};                  xr[4] = 32'h0;        xc[4] = 32'h0;
    send_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(v[i][0], v[i][1], v[i][2], v[i][3], 1'b0, lat, r_r, r_c);
      tests++; if (lat != LAT) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      tests++; if (r_r !== xr[i]) begin fails++; $display("FAIL dir%0d_cr got %h want %h", i, r_r, xr[i]); end
      tests++; if (r_c !== xc[i]) begin fails++; $display("FAIL dir%0d_cc got %h want %h", i, r_c, xc[i]); end
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
      if (i == 4) begin
        // read dbz while holding: result already consumed, dbz holds with cr/cc
        tests++; if (dbz !== 1'b1) begin fails++; $display("FAIL dir_dbz_set got %b want 1", dbz); end
      end
`endif
    end
    tests++; if (cr !== 32'h0 || cc !== 32'h0) begin fails++; $display("FAIL held_after_send got %h/%h want 0/0", cr, cc); end
    run_op(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0, lat, r_r, r_c);
    tests++; if (r_r !== 32'h000070A3 || r_c !== 32'h0000147A) begin fails++; $display("FAIL after_dbz got %h/%h want 000070a3/0000147a", r_r, r_c); end
`ifdef FIXED_POINT_COMPLEX_DIVIDER_DBZ_EN
    tests++; if (dbz !== 1'b0) begin fails++; $display("FAIL dir_dbz_clear got %b want 0", dbz); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a_r, a_c, b_r, b_c, e_r, e_c, r_r, r_c;
    int lat;
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_r = rnd(); a_c = rnd(); b_r = rnd(); b_c = rnd();
      model(a_r, a_c, b_r, b_c, e_r, e_c);
      run_op(a_r, a_c, b_r, b_c, 1'b0, lat, r_r, r_c);
      tests++; if (lat != LAT) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
      tests++; if (r_r !== e_r) begin fails++; $display("FAIL rnd%0d_cr got %h want %h (a=%h,%h b=%h,%h)", i, r_r, e_r, a_r, a_c, b_r, b_c); end
      tests++; if (r_c !== e_c) begin fails++; $display("FAIL rnd%0d_cc got %h want %h (a=%h,%h b=%h,%h)", i, r_c, e_c, a_r, a_c, b_r, b_c); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_r, a_c, b_r, b_c, e_r, e_c, r_r, r_c;
    int lat;
    send_rdy = 1'b0;
    a_r = rnd(); a_c = rnd(); b_r = 32'h00018000; b_c = 32'hFFFF4000;
    model(a_r, a_c, b_r, b_c, e_r, e_c);
    run_op(a_r, a_c, b_r, b_c, 1'b1, lat, r_r, r_c);
    tests++; if (lat != LAT || r_r !== e_r || r_c !== e_c) begin
      fails++; $display("FAIL bp_first got lat=%0d %h/%h want lat=%0d %h/%h", lat, r_r, r_c, LAT, e_r, e_c);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (send_val !== 1'b1 || recv_rdy !== 1'b0 || cr !== e_r || cc !== e_c) begin
        fails++; $display("FAIL bp_hold%0d got val=%b rdy=%b %h/%h want val=1 rdy=0 %h/%h", i, send_val, recv_rdy, cr, cc, e_r, e_c);
      end
    end
    @(negedge clk);
    send_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      fails++; $display("FAIL bp_release got val=%b rdy=%b want val=0 rdy=1", send_val, recv_rdy);
    end
    a_r = rnd(); a_c = rnd(); b_r = rnd(); b_c = rnd();
    model(a_r, a_c, b_r, b_c, e_r, e_c);
    run_op(a_r, a_c, b_r, b_c, 1'b0, lat, r_r, r_c);
    tests++; if (lat != LAT || r_r !== e_r || r_c !== e_c) begin
      fails++; $display("FAIL bp_second got lat=%0d %h/%h want lat=%0d %h/%h", lat, r_r, r_c, LAT, e_r, e_c);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e_r, e_c, r_r, r_c;
    int lat;
    send_rdy = 1'b1;
    @(negedge clk);
    ar = 32'h00070000; ac = 32'h00010000; br = 32'h00020000; bc = 32'h00010000;
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    repeat (100) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++; if (recv_rdy !== 1'b1 || send_val !== 1'b0 || cr !== 32'h0 || cc !== 32'h0) begin
      fails++; $display("FAIL mid_reset got rdy=%b val=%b %h/%h want rdy=1 val=0 0/0", recv_rdy, send_val, cr, cc);
    end
    @(negedge clk);
    reset = 1'b1;
    model(32'h00070000, 32'h00010000, 32'h00020000, 32'h00010000, e_r, e_c);
    run_op(32'h00070000, 32'h00010000, 32'h00020000, 32'h00010000, 1'b0, lat, r_r, r_c);
    tests++; if (lat != LAT) begin fails++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
    tests++; if (r_r !== e_r || r_c !== e_c) begin fails++; $display("FAIL post_reset_result got %h/%h want %h/%h", r_r, r_c, e_r, e_c); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
